seq_alu: RTL
============

// Module: seq_alu
// PURPOSE
//  Parametrised multi-cycle ALU for the datapath. It extends the 3-bit-op, 32-bit combinational ALU with:
//  - a valid/ready handshake on both input and output;
//  - registered flags;
//  - iterative unsigned multiply (shift-add) and divide (restoring), which return a double-width result.
//  Sits between the operand-fetch stage and writeback; the control unit stalls on in_ready / out_valid.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=4); iteration counter width = $clog2(WIDTH)+1
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands/op presented
//  in_ready   out  1      block can accept (high only in IDLE)
//  input1     in   WIDTH  operand A
//  input2     in   WIDTH  operand B
//  op         in   3      000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed), 110 MULU, 111 DIVU
//  out_valid  out  1      result held valid
//  out_ready  in   1      consumer accepts result
//  out        out  WIDTH  result / MUL low half / DIV quotient
//  out_hi     out  WIDTH  MUL high half / DIV remainder; 0 for all other ops
//  zero       out  1      out == 0
//  overflow   out  1      signed overflow (ADD/SUB only, else 0)
//  div_zero   out  1      DIVU with input2 == 0
// BEHAVIOUR
//  Reset (rst=1 at a clock edge):
//  - state<=IDLE; in_ready=1; out_valid, out, out_hi, zero, overflow, div_zero all 0.
//  - Reset wins over any in-flight op; a partial MUL/DIV is discarded.
//  Handshake:
//  - Accept on an edge where in_valid & in_ready. op and operands are latched; later input changes are ignored.
//  - Result is delivered on an edge where out_valid & out_ready, then state -> IDLE.
//  - No new accept occurs while BUSY or DONE; max throughput is 1 op / 2 cycles.
//  States IDLE -> (BUSY) -> DONE -> IDLE:
//  - IDLE: accept of op 000-101, or DIVU with input2==0 -> DONE at the next edge (latency 1 cycle).
//  - IDLE: accept of MULU, or DIVU with input2!=0 -> BUSY; counter<=WIDTH.
//  - BUSY: one iteration per cycle; counter decrements; when it reaches 0 -> DONE.
//    MULU/DIVU therefore deliver out_valid exactly WIDTH+1 edges after the accept edge.
//  - DONE: out_valid=1; all outputs stable until handshake. out_ready low holds the state indefinitely.
//  Arithmetic:
//  - ADD/SUB: modulo 2^WIDTH. overflow = operand signs agree (SUB: A and ~B) and result sign differs.
//  - SLT: out = {WIDTH-1 zeros, signed(A)<signed(B)}.
//  - MULU: {out_hi,out} = A*B unsigned, exact 2*WIDTH bits.
//  - DIVU: out = A/B, out_hi = A%B.
//    B==0: out = all ones, out_hi = A, div_zero=1.
//  - zero reflects out only (not out_hi). Flags are registered with the result.
// TESTING
//  1) ADD 10,5 -> out=15 one edge after accept, zero=0, out_hi=0; then SUB 10,5 -> 5.
//  2) SUB 5,10 -> out=32'hFFFFFFFB; ADD 32'h7FFFFFFF,1 -> out=32'h80000000, overflow=1; SUB 7,7 -> zero=1.
//  3) MULU 32'hFFFFFFFF,2 -> out=32'hFFFFFFFE, out_hi=1; out_valid exactly 33 edges after accept; in_ready=0 meanwhile.
//  4) DIVU 10,3 -> out=3, out_hi=1 after 33 edges; DIVU 10,0 -> out=32'hFFFFFFFF, out_hi=10, div_zero=1 after 1 edge.
//  5) Hold out_ready=0 for 10 cycles after AND 12,10; change the inputs -> out stays 8; in_valid ignored; release -> IDLE.
//  6) rst=1 at cycle 5 of a MULU -> next cycle all outputs 0, in_ready=1; a following ADD 1,1 -> 2.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU; ADD/SUB/logic/SLT/DIVU-by-0 complete at the accept edge, MULU/DIVU take WIDTH+1 further edges.
// Backpressure: result and flags are held in DONE until out_ready; in_ready is high only in IDLE.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_MULU = 3'b110;
    localparam logic [2:0] OP_DIVU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] hi;
        logic             zero;
        logic             overflow;
        logic             div_zero;
    } res_t;

    state_t           state;
    state_t           state_nxt;
    res_t             res_q;
    res_t             quick_res;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] acc_hi_nxt;
    logic [WIDTH-1:0] acc_lo_nxt;
    logic [WIDTH-1:0] opnd_q;
    logic             is_mul_q;
    logic [CW-1:0]    count;
    logic             long_op;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    assign long_op   = (op == OP_MULU) || ((op == OP_DIVU) && (input2 != '0));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign out      = res_q.lo;
    assign out_hi   = res_q.hi;
    assign zero     = res_q.zero;
    assign overflow = res_q.overflow;
    assign div_zero = res_q.div_zero;

    // Single-cycle results, computed straight from the presented operands.
    always_comb begin
        sum       = input1 + input2;
        diff      = input1 - input2;
        quick_res = '0;
        case (op)
            OP_ADD: begin
                quick_res.lo       = sum;
                quick_res.overflow = (input1[WIDTH-1] == input2[WIDTH-1]) &&
                                     (sum[WIDTH-1] != input1[WIDTH-1]);
            end
            OP_SUB: begin
                quick_res.lo       = diff;
                quick_res.overflow = (input1[WIDTH-1] != input2[WIDTH-1]) &&
                                     (diff[WIDTH-1] != input1[WIDTH-1]);
            end
            OP_AND:  quick_res.lo = input1 & input2;
            OP_OR:   quick_res.lo = input1 | input2;
            OP_XOR:  quick_res.lo = input1 ^ input2;
            OP_SLT:  quick_res.lo = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
            OP_DIVU: begin
                quick_res.lo       = '1;
                quick_res.hi       = input1;
                quick_res.div_zero = 1'b1;
            end
            default: quick_res.lo = '0;
        endcase
        quick_res.zero = (quick_res.lo == '0);
    end

    // One shift-add (MULU) or restoring-divide (DIVU) step on {acc_hi, acc_lo}.
    always_comb begin
        mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
        div_shift  = {acc_hi, acc_lo[WIDTH-1]};
        div_diff   = div_shift - {1'b0, opnd_q};
        acc_hi_nxt = acc_hi;
        acc_lo_nxt = acc_lo;
        if (is_mul_q) begin
            {acc_hi_nxt, acc_lo_nxt} = {mul_sum, acc_lo[WIDTH-1:1]};
        end else if (div_shift >= {1'b0, opnd_q}) begin
            acc_hi_nxt = div_diff[WIDTH-1:0];
            acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            acc_hi_nxt = div_shift[WIDTH-1:0];
            acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = long_op ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (count == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // MULU: acc_lo starts as the multiplier, opnd_q holds the multiplicand.
    // DIVU: acc_lo starts as the dividend and fills with quotient bits, opnd_q holds the divisor.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd_q   <= '0;
            is_mul_q <= 1'b0;
            count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (long_op) begin
                            is_mul_q <= (op == OP_MULU);
                            opnd_q   <= (op == OP_MULU) ? input1 : input2;
                            acc_lo   <= (op == OP_MULU) ? input2 : input1;
                            acc_hi   <= '0;
                            count    <= CW'(WIDTH);
                        end else begin
                            res_q <= quick_res;
                        end
                    end
                end
                BUSY: begin
                    if (count != '0) begin
                        acc_hi <= acc_hi_nxt;
                        acc_lo <= acc_lo_nxt;
                        count  <= count - CW'(1);
                    end else begin
                        res_q.lo       <= acc_lo;
                        res_q.hi       <= acc_hi;
                        res_q.zero     <= (acc_lo == '0);
                        res_q.overflow <= 1'b0;
                        res_q.div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
